// File: rtl/bsg_cycle_stamp_fifo.sv
// Stamps each event with the free-running cycle count and queues the stamps
// in a small FIFO popped through valid/yumi; dropped events are counted.
module bsg_cycle_stamp_fifo #(
  parameter int width_p      = 64,
  parameter int els_p        = 4,
  parameter int drop_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [width_p-1:0]      ctr_i,
  input  logic                    event_i,
  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  input  logic                    yumi_i,
  output logic                    overflow_o,
  output logic [drop_width_p-1:0] dropped_o,
  input  logic                    clear_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp:0] els_lp = (ptr_w_lp+1)'(els_p);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_w_lp-1:0]     rd_ptr_r, wr_ptr_r;
  logic [ptr_w_lp:0]       count_r;
  logic                    overflow_r;
  logic [drop_width_p-1:0] dropped_r;

  logic full, pop, push, drop;

  function automatic logic [drop_width_p-1:0] sat_inc(input logic [drop_width_p-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the event.
  assign full = (count_r == els_lp);
  assign pop  = yumi_i & (count_r != '0);
  assign push = event_i & (~full | pop);
  assign drop = event_i & full & ~pop;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= ctr_i;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop) rd_ptr_r <= rd_ptr_r + 1'b1;
      unique case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // A drop coinciding with clear survives as the first count after the clear.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_r <= 1'b0;
      dropped_r  <= '0;
    end else if (clear_i) begin
      overflow_r <= drop;
      dropped_r  <= drop ? drop_width_p'(1) : '0;
    end else if (drop) begin
      overflow_r <= 1'b1;
      dropped_r  <= sat_inc(dropped_r);
    end
  end

  assign v_o        = (count_r != '0);
  assign data_o     = mem_r[rd_ptr_r];
  assign overflow_o = overflow_r;
  assign dropped_o  = dropped_r;

endmodule

// File: tb/tb_bsg_cycle_stamp_fifo.sv
// Directed bench for bsg_cycle_stamp_fifo: a default-sized instance plus a
// small instance with a 2-bit drop counter for saturation checks.
module tb_bsg_cycle_stamp_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [63:0] ctr = '0;
  logic        ev = 1'b0, yumi = 1'b0, clr = 1'b0;
  logic        v, ov;
  logic [63:0] data;
  logic [7:0]  dropped;

  logic [15:0] ctr2 = '0;
  logic        ev2 = 1'b0, yumi2 = 1'b0, clr2 = 1'b0;
  logic        v2, ov2;
  logic [15:0] data2;
  logic [1:0]  dropped2;

  int n_cmp = 0;
  int n_bad = 0;

  bsg_cycle_stamp_fifo #(.width_p(64), .els_p(4), .drop_width_p(8)) dut (
    .clk_i(clk), .reset_i(rst), .ctr_i(ctr), .event_i(ev), .v_o(v),
    .data_o(data), .yumi_i(yumi), .overflow_o(ov), .dropped_o(dropped),
    .clear_i(clr)
  );

  bsg_cycle_stamp_fifo #(.width_p(16), .els_p(2), .drop_width_p(2)) dut2 (
    .clk_i(clk), .reset_i(rst), .ctr_i(ctr2), .event_i(ev2), .v_o(v2),
    .data_o(data2), .yumi_i(yumi2), .overflow_o(ov2), .dropped_o(dropped2),
    .clear_i(clr2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(yumi && !v)) else $error("illegal yumi on dut with v_o=0");
      assert (!(yumi2 && !v2)) else $error("illegal yumi on dut2 with v_o=0");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    n_cmp++; if (v !== 1'b0)    begin n_bad++; $display("FAIL reset_v got %0d want 0", v); end
    n_cmp++; if (data !== 64'd0) begin n_bad++; $display("FAIL reset_data got %0d want 0", data); end
    n_cmp++; if (ov !== 1'b0)   begin n_bad++; $display("FAIL reset_ov got %0d want 0", ov); end
    n_cmp++; if (dropped !== 8'd0) begin n_bad++; $display("FAIL reset_dropped got %0d want 0", dropped); end
  endtask

  task automatic test_single();
    ev = 1'b1; ctr = 64'd100;
    tick();
    ev = 1'b0; ctr = 64'd101;
    n_cmp++; if (v !== 1'b1)       begin n_bad++; $display("FAIL single_v got %0d want 1", v); end
    n_cmp++; if (data !== 64'd100) begin n_bad++; $display("FAIL single_data got %0d want 100", data); end
    tick();
    n_cmp++; if (data !== 64'd100) begin n_bad++; $display("FAIL single_hold got %0d want 100", data); end
    yumi = 1'b1;
    tick();
    yumi = 1'b0;
    n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL single_pop_v got %0d want 0", v); end
  endtask

  task automatic test_order();
    for (int i = 0; i < 4; i++) begin
      ev = 1'b1; ctr = 64'(10 + i);
      tick();
    end
    ev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL order_v[%0d] got %0d want 1", i, v); end
      n_cmp++; if (data !== 64'(10 + i)) begin n_bad++; $display("FAIL order_data[%0d] got %0d want %0d", i, data, 10 + i); end
      yumi = 1'b1; tick(); yumi = 1'b0;
    end
    n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL order_empty got %0d want 0", v); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      ev = 1'b1; ctr = 64'(20 + i);
      tick();
    end
    ev = 1'b0;
    n_cmp++; if (dropped !== 8'd2) begin n_bad++; $display("FAIL ovf_dropped got %0d want 2", dropped); end
    n_cmp++; if (ov !== 1'b1)      begin n_bad++; $display("FAIL ovf_flag got %0d want 1", ov); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (data !== 64'(20 + i)) begin n_bad++; $display("FAIL ovf_data[%0d] got %0d want %0d", i, data, 20 + i); end
      yumi = 1'b1; tick(); yumi = 1'b0;
    end
    clr = 1'b1; tick(); clr = 1'b0;
    n_cmp++; if (dropped !== 8'd0) begin n_bad++; $display("FAIL clr_dropped got %0d want 0", dropped); end
    n_cmp++; if (ov !== 1'b0)      begin n_bad++; $display("FAIL clr_flag got %0d want 0", ov); end
    n_cmp++; if (v !== 1'b0)       begin n_bad++; $display("FAIL ovf_empty got %0d want 0", v); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      ev = 1'b1; ctr = 64'(30 + i);
      tick();
    end
    ev = 1'b1; yumi = 1'b1; ctr = 64'd50;
    tick();
    ev = 1'b0; yumi = 1'b0;
    n_cmp++; if (dropped !== 8'd0) begin n_bad++; $display("FAIL b2b_dropped got %0d want 0", dropped); end
    n_cmp++; if (ov !== 1'b0)      begin n_bad++; $display("FAIL b2b_flag got %0d want 0", ov); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (data !== 64'(31 + i)) begin n_bad++; $display("FAIL b2b_data[%0d] got %0d want %0d", i, data, 31 + i); end
      yumi = 1'b1; tick(); yumi = 1'b0;
    end
    n_cmp++; if (data !== 64'd50) begin n_bad++; $display("FAIL b2b_head got %0d want 50", data); end
    yumi = 1'b1; tick(); yumi = 1'b0;
    n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got %0d want 0", v); end
  endtask

  task automatic test_wrap();
    ev = 1'b1; ctr = 64'hFFFF_FFFF_FFFF_FFFF; tick();
    ctr = 64'd0; tick();
    ev = 1'b0;
    n_cmp++; if (data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL wrap_hi got %0h want ffffffffffffffff", data); end
    yumi = 1'b1; tick(); yumi = 1'b0;
    n_cmp++; if (data !== 64'd0) begin n_bad++; $display("FAIL wrap_lo got %0h want 0", data); end
    yumi = 1'b1; tick(); yumi = 1'b0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 2; i++) begin
      ev2 = 1'b1; ctr2 = 16'(200 + i); tick();
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (dropped2 !== 2'd3) begin n_bad++; $display("FAIL sat4_dropped got %0d want 3", dropped2); end
    clr2 = 1'b1; tick(); clr2 = 1'b0;
    n_cmp++; if (dropped2 !== 2'd1) begin n_bad++; $display("FAIL clr_drop_dropped got %0d want 1", dropped2); end
    n_cmp++; if (ov2 !== 1'b1)      begin n_bad++; $display("FAIL clr_drop_flag got %0d want 1", ov2); end
    ev2 = 1'b0; clr2 = 1'b1; tick(); clr2 = 1'b0;
    n_cmp++; if (dropped2 !== 2'd0) begin n_bad++; $display("FAIL clr2_dropped got %0d want 0", dropped2); end
    ev2 = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    ev2 = 1'b0;
    n_cmp++; if (dropped2 !== 2'd3) begin n_bad++; $display("FAIL sat6_dropped got %0d want 3", dropped2); end
    n_cmp++; if (ov2 !== 1'b1)      begin n_bad++; $display("FAIL sat6_flag got %0d want 1", ov2); end
    n_cmp++; if (data2 !== 16'd200) begin n_bad++; $display("FAIL sat_head got %0d want 200", data2); end
  endtask

  task automatic test_async_reset();
    ev = 1'b1; ctr = 64'd77; tick();
    ctr = 64'd78; tick();
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL pre_rst_v got %0d want 1", v); end
    rst = 1'b1;
    #1;
    n_cmp++; if (v !== 1'b0)       begin n_bad++; $display("FAIL async_rst_v got %0d want 0", v); end
    n_cmp++; if (data !== 64'd0)   begin n_bad++; $display("FAIL async_rst_data got %0d want 0", data); end
    n_cmp++; if (dropped2 !== 2'd0) begin n_bad++; $display("FAIL async_rst_dropped got %0d want 0", dropped2); end
    n_cmp++; if (v2 !== 1'b0)      begin n_bad++; $display("FAIL async_rst_v2 got %0d want 0", v2); end
    ev = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL post_rst_v got %0d want 0", v); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_saturate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
